// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped 2-bit counters with tagged targets.
// Optional performance counters are enabled by defining BRANCH_PRED_PERF_EN.
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    output logic        ready_o,
    input  logic        lookup_valid_i,
    input  logic [31:0] lookup_pc_i,
    output logic        pred_valid_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        update_valid_i,
    input  logic [31:0] update_pc_i,
    input  logic        update_taken_i,
    input  logic [31:0] update_target_i
`ifdef BRANCH_PRED_PERF_EN
    ,
    input  logic        update_pred_taken_i,
    output logic [31:0] perf_lookups_o,
    output logic [31:0] perf_hits_o,
    output logic [31:0] perf_mispredicts_o
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   sweep_idx;

    logic               valid_mem  [ENTRIES];
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [1:0]         ctr_mem    [ENTRIES];
    logic [31:0]        target_mem [ENTRIES];

    logic [IDX_W-1:0]   lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit;
    logic               lk_taken;
    logic [31:0]        lk_target;

    logic [IDX_W-1:0]   up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               up_hit;
    logic               up_en;

    logic               pred_valid_p1;
    logic               pred_taken_p1;
    logic [31:0]        pred_target_p1;

    logic               unused_pc_bits;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = INIT;
        end else begin
            case (state)
                INIT:    if (sweep_idx == LAST_IDX) state_nxt = RUN;
                RUN:     state_nxt = RUN;
                default: state_nxt = INIT;
            endcase
        end
    end

    always_comb begin
        ready_o = (state == RUN);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sweep_idx <= '0;
        end else if (flush_i) begin
            sweep_idx <= '0;
        end else if (state == INIT) begin
            sweep_idx <= sweep_idx + 1'b1;
        end
    end

    // Stage p0: lookup reads the arrays combinationally, before this cycle's write lands.
    always_comb begin
        lk_idx    = lookup_pc_i[IDX_W+1:2];
        lk_tag    = lookup_pc_i[IDX_W+TAG_W+1:IDX_W+2];
        lk_hit    = valid_mem[lk_idx] && (tag_mem[lk_idx] == lk_tag);
        lk_taken  = ready_o && lk_hit && ctr_mem[lk_idx][1];
        lk_target = lk_taken ? target_mem[lk_idx] : lookup_pc_i + 32'd4;
    end

    always_comb begin
        up_idx = update_pc_i[IDX_W+1:2];
        up_tag = update_pc_i[IDX_W+TAG_W+1:IDX_W+2];
        up_hit = valid_mem[up_idx] && (tag_mem[up_idx] == up_tag);
        up_en  = update_valid_i && ready_o && !flush_i;
    end

    assign unused_pc_bits = ^update_pc_i;

    // Stage p1: registered prediction presented to fetch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pred_valid_p1  <= 1'b0;
            pred_taken_p1  <= 1'b0;
            pred_target_p1 <= '0;
        end else begin
            pred_valid_p1  <= lookup_valid_i;
            pred_taken_p1  <= lk_taken;
            pred_target_p1 <= lk_target;
        end
    end

    assign pred_valid_o  = pred_valid_p1;
    assign pred_taken_o  = pred_taken_p1;
    assign pred_target_o = pred_target_p1;

    // Arrays carry no reset; the INIT sweep is what makes their contents defined.
    always_ff @(posedge clk_i) begin
        if (state == INIT) begin
            valid_mem[sweep_idx]  <= 1'b0;
            tag_mem[sweep_idx]    <= '0;
            ctr_mem[sweep_idx]    <= 2'b01;
            target_mem[sweep_idx] <= '0;
        end else if (up_en) begin
            if (up_hit) begin
                if (update_taken_i) begin
                    ctr_mem[up_idx]    <= ctr_inc(ctr_mem[up_idx]);
                    target_mem[up_idx] <= update_target_i;
                end else begin
                    ctr_mem[up_idx]    <= ctr_dec(ctr_mem[up_idx]);
                end
            end else if (update_taken_i) begin
                valid_mem[up_idx]  <= 1'b1;
                tag_mem[up_idx]    <= up_tag;
                ctr_mem[up_idx]    <= 2'b10;
                target_mem[up_idx] <= update_target_i;
            end
        end
    end

`ifdef BRANCH_PRED_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_lookups_o     <= '0;
            perf_hits_o        <= '0;
            perf_mispredicts_o <= '0;
        end else if (flush_i) begin
            perf_lookups_o     <= '0;
            perf_hits_o        <= '0;
            perf_mispredicts_o <= '0;
        end else begin
            if (lookup_valid_i && ready_o) begin
                perf_lookups_o <= perf_lookups_o + 32'd1;
            end
            if (lookup_valid_i && ready_o && lk_hit) begin
                perf_hits_o <= perf_hits_o + 32'd1;
            end
            if (update_valid_i && ready_o && (update_pred_taken_i != update_taken_i)) begin
                perf_mispredicts_o <= perf_mispredicts_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized bench for branch_predictor against a table-level behavioural model.
module tb_branch_predictor;

    localparam int ENTRIES = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ready;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
`ifdef BRANCH_PRED_PERF_EN
    logic        update_pred_taken = 1'b0;
    logic [31:0] perf_lookups;
    logic [31:0] perf_hits;
    logic [31:0] perf_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(8)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_i         (flush),
        .ready_o         (ready),
        .lookup_valid_i  (lookup_valid),
        .lookup_pc_i     (lookup_pc),
        .pred_valid_o    (pred_valid),
        .pred_taken_o    (pred_taken),
        .pred_target_o   (pred_target),
        .update_valid_i  (update_valid),
        .update_pc_i     (update_pc),
        .update_taken_i  (update_taken),
        .update_target_i (update_target)
`ifdef BRANCH_PRED_PERF_EN
        ,
        .update_pred_taken_i (update_pred_taken),
        .perf_lookups_o      (perf_lookups),
        .perf_hits_o         (perf_hits),
        .perf_mispredicts_o  (perf_mispredicts)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    logic        exp_ready;
    logic        exp_pv;
    logic        exp_taken;
    logic [31:0] exp_target;

    // Model: one record per table slot, plus a count of sweep cycles still owed.
    bit          m_v  [ENTRIES];
    int unsigned m_t  [ENTRIES];
    int          m_c  [ENTRIES];
    logic [31:0] m_tg [ENTRIES];
    int          sweep_rem;

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) m_v[i] = 0;
        sweep_rem = ENTRIES;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", {31'd0, ready}, {31'd0, exp_ready});
            chk("pred_valid", {31'd0, pred_valid}, {31'd0, exp_pv});
            if (exp_pv) begin
                chk("pred_taken", {31'd0, pred_taken}, {31'd0, exp_taken});
                chk("pred_target", pred_target, exp_target);
            end
        end
    end

    // Drives one cycle of inputs, predicts the outputs after the edge, returns at negedge+1.
    task automatic step(input bit lv, input logic [31:0] lpc, input bit fl,
                        input bit uv, input logic [31:0] upc, input bit ut,
                        input logic [31:0] utg);
        bit          rdy;
        int unsigned li, ui, ltag, utag;
        bit          lhit, uhit;
        lookup_valid  = lv;
        lookup_pc     = lpc;
        flush         = fl;
        update_valid  = uv;
        update_pc     = upc;
        update_taken  = ut;
        update_target = utg;

        rdy  = (sweep_rem == 0);
        li   = (lpc / 4) % ENTRIES;
        ltag = (lpc / (4 * ENTRIES)) % 256;
        ui   = (upc / 4) % ENTRIES;
        utag = (upc / (4 * ENTRIES)) % 256;
        lhit = m_v[li] && (m_t[li] == ltag);
        uhit = m_v[ui] && (m_t[ui] == utag);

        exp_pv     = lv;
        exp_taken  = rdy && lhit && (m_c[li] >= 2);
        exp_target = exp_taken ? m_tg[li] : lpc + 32'd4;

        if (fl) begin
            model_reset();
        end else if (!rdy) begin
            sweep_rem--;
        end else if (uv) begin
            if (uhit) begin
                if (ut) begin
                    m_c[ui]  = (m_c[ui] == 3) ? 3 : m_c[ui] + 1;
                    m_tg[ui] = utg;
                end else begin
                    m_c[ui]  = (m_c[ui] == 0) ? 0 : m_c[ui] - 1;
                end
            end else if (ut) begin
                m_v[ui]  = 1;
                m_t[ui]  = utag;
                m_c[ui]  = 2;
                m_tg[ui] = utg;
            end
        end
        exp_ready = (sweep_rem == 0);
        chk_en = 1;
        @(negedge clk);
        #1;
    endtask

    task automatic look(input logic [31:0] pc);
        step(1, pc, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] tg);
        step(0, 0, 0, 1, pc, t, tg);
    endtask

    task automatic expect_pred(input string name, input bit t, input logic [31:0] tg);
        chk({name, "_taken"}, {31'd0, pred_taken}, {31'd0, t});
        chk({name, "_target"}, pred_target, tg);
    endtask

    // Counts observations with ready low until the sweep completes, then pins the length.
    task automatic sweep_and_check(input string name, input logic [31:0] pc);
        int zeros;
        zeros = (ready == 1'b0) ? 1 : 0;
        for (int k = 1; k <= ENTRIES; k++) begin
            look(pc);
            if (ready == 1'b0) zeros++;
        end
        chk({name, "_len"}, zeros, ENTRIES);
        chk({name, "_ready"}, {31'd0, ready}, 32'd1);
    endtask

    task automatic do_reset(input string name);
        chk_en = 0;
        rst = 1'b1;
        #1;
        chk({name, "_ready"}, {31'd0, ready}, 32'd0);
        chk({name, "_pv"}, {31'd0, pred_valid}, 32'd0);
        chk({name, "_taken"}, {31'd0, pred_taken}, 32'd0);
        chk({name, "_target"}, pred_target, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        if ($urandom_range(0, 49) == 0) begin
            pc = 32'hFFFF_FFFC;
        end else begin
            pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2);
        end
        return pc;
    endfunction

    initial begin
        rst = 1'b1;
        flush = 0; lookup_valid = 0; lookup_pc = 0;
        update_valid = 0; update_pc = 0; update_taken = 0; update_target = 0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_pv", {31'd0, pred_valid}, 32'd0);
        chk("rst_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst_target", pred_target, 32'd0);
        rst = 1'b0;

        sweep_and_check("sweep0", 32'h100);
        expect_pred("init_lookup", 0, 32'h104);

        upd(32'h200, 1, 32'h80);
        look(32'h200);
        expect_pred("train_200", 1, 32'h80);
        upd(32'h200, 0, 0);
        look(32'h200);
        expect_pred("weak_200", 0, 32'h204);

        for (int i = 0; i < 4; i++) upd(32'h300, 1, 32'h3000);
        look(32'h300);
        expect_pred("sat_300", 1, 32'h3000);
        upd(32'h300, 0, 0);
        upd(32'h300, 0, 0);
        look(32'h300);
        expect_pred("dec_300", 0, 32'h304);
        upd(32'h400, 0, 0);
        look(32'h400);
        expect_pred("nt_miss_400", 0, 32'h404);

        upd(32'h200, 1, 32'h90);
        look(32'h200);
        expect_pred("alias_pre", 1, 32'h90);
        upd(32'h300, 1, 32'hA0);
        look(32'h200);
        expect_pred("alias_200", 0, 32'h204);
        look(32'h300);
        expect_pred("alias_300", 1, 32'hA0);

        step(1, 32'h500, 0, 1, 32'h500, 1, 32'h55);
        expect_pred("rbw_same", 0, 32'h504);
        look(32'h500);
        expect_pred("rbw_next", 1, 32'h55);

        look(32'hFFFF_FFFC);
        expect_pred("wrap", 0, 32'h0);

        step(1, 32'h500, 1, 1, 32'h600, 1, 32'h66);
        sweep_and_check("flush", 32'h500);
        look(32'h500);
        expect_pred("post_flush_500", 0, 32'h504);
        look(32'h600);
        expect_pred("flush_drop_600", 0, 32'h604);

        upd(32'h700, 1, 32'h77);
        look(32'h700);
        expect_pred("train_700", 1, 32'h77);
        do_reset("rst_run");
        for (int i = 0; i < 20; i++) look(32'h100);
        do_reset("rst_mid");
        sweep_and_check("sweep_rst", 32'h100);
        look(32'h700);
        expect_pred("post_rst_700", 0, 32'h704);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, rand_pc(),
                 $urandom_range(0, 299) == 0,
                 $urandom_range(0, 1) == 1, rand_pc(),
                 $urandom_range(0, 2) != 0, $urandom);
        end
        chk_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
